if_prefetch_stage: RTL and testbench

- Parametrised next-generation fetch stage: PC sequencer, variable-latency instruction-memory handshake, and a DEPTH-entry prefetch FIFO that decouples fetch from the ID stage.
- Sits between the instruction memory port and the IF/ID pipeline register.
- Handles branch redirect with queue flush, discard of in-flight responses, and freeze-based backpressure.

---
 rtl/if_prefetch_stage_if.sv | 25 ++
 rtl/if_prefetch_stage.sv | 178 +++++++++++++++++
 tb/tb_if_prefetch_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and the memory (slave).
// At most one request is outstanding; imem_rvalid completes it.
interface if_prefetch_stage_if #(
    parameter int ADDR_LEN  = 32,
    parameter int INSTR_LEN = 32
) ();
    logic                 imem_req;
    logic [ADDR_LEN-1:0]  imem_addr;
    logic                 imem_rvalid;
    logic [INSTR_LEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// Fetch stage: PC sequencer, single-outstanding imem handshake and a prefetch FIFO toward ID.
// Optional macro IF_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module if_prefetch_stage #(
    parameter int                  ADDR_LEN   = 32,
    parameter int                  INSTR_LEN  = 32,
    parameter int                  FIFO_DEPTH = 4,
    parameter int                  PC_STEP    = 4,
    parameter logic [ADDR_LEN-1:0] RESET_PC   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    freeze,
    input  logic                    Branch_taken,
    input  logic [ADDR_LEN-1:0]     BranchAddr,
    if_prefetch_stage_if.master     imem,
    output logic                    out_valid,
    output logic [INSTR_LEN-1:0]    Instruction,
    output logic [ADDR_LEN-1:0]     PC
);
    localparam int                  PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                  CNT_W   = PTR_W + 1;
    localparam logic [ADDR_LEN-1:0] STEP    = ADDR_LEN'(PC_STEP);
    localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t               state, state_next;
    logic [ADDR_LEN-1:0]  fetch_pc, fetch_pc_next, pc_inc;
    logic                 req_q, req_next;
    logic [ADDR_LEN-1:0]  addr_q, addr_next;

    logic [INSTR_LEN-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_LEN-1:0]  fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count, count_next;
    logic [INSTR_LEN-1:0] last_instr, head_instr;
    logic [ADDR_LEN-1:0]  last_pc, head_pc;

    logic fifo_empty, accept, push, pop, bypass_hit, bypass_take;

    assign pc_inc     = fetch_pc + STEP;
    assign fifo_empty = (count == '0);
    assign accept     = (state == WAIT) && imem.imem_rvalid && !Branch_taken;

`ifdef IF_BYPASS_EN
    assign bypass_hit = fifo_empty && accept;
`else
    assign bypass_hit = 1'b0;
`endif

    assign bypass_take = bypass_hit && !freeze;
    assign push        = accept && !bypass_take;
    assign pop         = !fifo_empty && !freeze && !Branch_taken;

    assign head_instr = fifo_empty ? last_instr : fifo_instr[rd_ptr];
    assign head_pc    = fifo_empty ? last_pc    : fifo_pc[rd_ptr];

    // Occupancy after this edge; a redirect empties the queue regardless of push/pop.
    always_comb begin
        count_next = count;
        if (Branch_taken) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_next      = req_q;
        addr_next     = addr_q;
        if (Branch_taken) begin
            fetch_pc_next = BranchAddr;
        end
        case (state)
            IDLE: begin
                if (!Branch_taken && (count < DEPTH_C)) begin
                    req_next   = 1'b1;
                    addr_next  = fetch_pc;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (Branch_taken) begin
                    // Without a response the old request is still in flight and must be drained.
                    if (imem.imem_rvalid) begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                    end else begin
                        state_next = DISCARD;
                    end
                end else if (imem.imem_rvalid) begin
                    fetch_pc_next = pc_inc;
                    if (count_next < DEPTH_C) begin
                        addr_next = pc_inc;
                    end else begin
                        req_next   = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (imem.imem_rvalid) begin
                    req_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_q    <= req_next;
            addr_q   <= addr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem.imem_rdata;
            fifo_pc[wr_ptr]    <= pc_inc;
        end
    end

    // Last consumed word is kept so the outputs hold steady while the queue is empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_instr <= '0;
            last_pc    <= '0;
        end else begin
            if (Branch_taken) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            if (pop) begin
                last_instr <= head_instr;
                last_pc    <= head_pc;
            end else if (bypass_take) begin
                last_instr <= imem.imem_rdata;
                last_pc    <= pc_inc;
            end
        end
    end

    always_comb begin
        out_valid   = !fifo_empty;
        Instruction = head_instr;
        PC          = head_pc;
`ifdef IF_BYPASS_EN
        if (bypass_hit) begin
            out_valid   = 1'b1;
            Instruction = imem.imem_rdata;
            PC          = pc_inc;
        end
`endif
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: streaming, freeze backpressure, redirects, PC wrap, reset.
// Memory word for address a is 0xC0DE0000 ^ a, with a programmable number of wait states.
module tb_if_prefetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        freeze = 1'b0;
    logic        Branch_taken = 1'b0;
    logic [31:0] BranchAddr = '0;
    logic        out_valid;
    logic [31:0] Instruction;
    logic [31:0] PC;

    logic auto_mem = 1'b1;
    logic manual_rvalid = 1'b0;
    int   wait_states = 0;
    int   wcnt = 0;
    int   checks = 0;
    int   errors = 0;

    if_prefetch_stage_if #(.ADDR_LEN(32), .INSTR_LEN(32)) mem ();

    if_prefetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .freeze       (freeze),
        .Branch_taken (Branch_taken),
        .BranchAddr   (BranchAddr),
        .imem         (mem),
        .out_valid    (out_valid),
        .Instruction  (Instruction),
        .PC           (PC)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign mem.imem_rvalid = auto_mem ? (mem.imem_req && (wcnt == wait_states)) : manual_rvalid;
    assign mem.imem_rdata  = mem_word(mem.imem_addr);

    always @(posedge clk) begin
        if (!mem.imem_req || mem.imem_rvalid) wcnt <= 0;
        else                                  wcnt <= wcnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset asserted after two edges; the caller releases it.
    task automatic do_reset(input int ws, input logic frz);
        reset = 1'b0;
        freeze = frz;
        Branch_taken = 1'b0;
        BranchAddr = '0;
        auto_mem = 1'b1;
        manual_rvalid = 1'b0;
        wait_states = ws;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        do_reset(0, 1'b0);
        checks++; if (mem.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b exp 0", mem.imem_req); end
        checks++; if (mem.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr got %h exp 0", mem.imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (Instruction !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got %h exp 0", Instruction); end
        checks++; if (PC !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc got %h exp 0", PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset(0, 1'b0);
        reset = 1'b1;
        tick();
        checks++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL seq_first_req got %b/%h exp 1/0", mem.imem_req, mem.imem_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_early_valid got %b exp 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc = 32'(4 * i + 4);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (Instruction !== mem_word(32'(4 * i))) begin errors++; $display("[TB] FAIL seq_instr[%0d] got %h exp %h", i, Instruction, mem_word(32'(4 * i))); end
            checks++; if (PC !== exp_pc) begin errors++; $display("[TB] FAIL seq_pc[%0d] got %h exp %h", i, PC, exp_pc); end
            checks++; if (mem.imem_addr !== exp_pc) begin errors++; $display("[TB] FAIL seq_addr[%0d] got %h exp %h", i, mem.imem_addr, exp_pc); end
        end
    endtask

    task automatic test_freeze();
        int          pushes;
        logic        seen;
        logic [31:0] first_addr;
        logic [31:0] exp_pc;
        pushes = 0;
        seen = 1'b0;
        first_addr = '1;
        do_reset(0, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (mem.imem_req === 1'b1 && mem.imem_rvalid === 1'b1) pushes++;
            tick();
        end
        checks++; if (pushes !== 4) begin errors++; $display("[TB] FAIL frz_pushes got %0d exp 4", pushes); end
        checks++; if (mem.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL frz_req got %b exp 0", mem.imem_req); end
        checks++; if (out_valid !== 1'b1 || PC !== 32'h4) begin errors++; $display("[TB] FAIL frz_head got %b/%h exp 1/00000004", out_valid, PC); end
        freeze = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(4 * i + 4);
            checks++; if (PC !== exp_pc || Instruction !== mem_word(32'(4 * i))) begin errors++; $display("[TB] FAIL drain[%0d] got %h/%h exp %h/%h", i, PC, Instruction, exp_pc, mem_word(32'(4 * i))); end
            if (!seen && mem.imem_req === 1'b1) begin
                seen = 1'b1;
                first_addr = mem.imem_addr;
            end
            tick();
        end
        checks++; if (first_addr !== 32'h10) begin errors++; $display("[TB] FAIL frz_resume_addr got %h exp 00000010", first_addr); end
        checks++; if (PC !== 32'h14 || Instruction !== mem_word(32'h10)) begin errors++; $display("[TB] FAIL frz_resume_head got %h/%h exp 00000014/%h", PC, Instruction, mem_word(32'h10)); end
    endtask

    task automatic test_branch_wait();
        logic found;
        found = 1'b0;
        do_reset(3, 1'b0);
        reset = 1'b1;
        tick();
        Branch_taken = 1'b1;
        BranchAddr = 32'h100;
        tick();
        Branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL brw_hold[%0d] got %b/%h exp 1/0", i, mem.imem_req, mem.imem_addr); end
            tick();
        end
        checks++; if (mem.imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL brw_discard got req %b valid %b exp 0/0", mem.imem_req, out_valid); end
        tick();
        checks++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL brw_target got %b/%h exp 1/00000100", mem.imem_req, mem.imem_addr); end
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (out_valid === 1'b1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL brw_timeout got no out_valid exp out_valid within 10 cycles"); end
        else if (PC !== 32'h104 || Instruction !== mem_word(32'h100)) begin errors++; $display("[TB] FAIL brw_first got %h/%h exp 00000104/%h", PC, Instruction, mem_word(32'h100)); end
    endtask

    task automatic test_branch_full();
        do_reset(0, 1'b1);
        reset = 1'b1;
        repeat (4) tick();
        checks++; if (mem.imem_rvalid !== 1'b1 || mem.imem_addr !== 32'hC || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL brf_setup got rv %b addr %h valid %b exp 1/0000000c/1", mem.imem_rvalid, mem.imem_addr, out_valid); end
        Branch_taken = 1'b1;
        BranchAddr = 32'h200;
        tick();
        Branch_taken = 1'b0;
        checks++; if (out_valid !== 1'b0 || mem.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL brf_flush got valid %b req %b exp 0/0", out_valid, mem.imem_req); end
        tick();
        checks++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL brf_target got %b/%h exp 1/00000200", mem.imem_req, mem.imem_addr); end
    endtask

    task automatic test_pc_wrap();
        do_reset(0, 1'b0);
        reset = 1'b1;
        tick();
        Branch_taken = 1'b1;
        BranchAddr = 32'hFFFF_FFFC;
        tick();
        Branch_taken = 1'b0;
        tick();
        checks++; if (mem.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_req got %h exp fffffffc", mem.imem_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || PC !== 32'h0 || Instruction !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("[TB] FAIL wrap_head got %b/%h/%h exp 1/00000000/%h", out_valid, PC, Instruction, mem_word(32'hFFFF_FFFC)); end
        checks++; if (mem.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next_addr got %h exp 0", mem.imem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset(3, 1'b0);
        reset = 1'b1;
        tick();
        checks++; if (mem.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rmid_req got %b exp 1", mem.imem_req); end
        reset = 1'b0;
        auto_mem = 1'b0;
        manual_rvalid = 1'b0;
        tick();
        checks++; if (mem.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rmid_drop got %b exp 0", mem.imem_req); end
        manual_rvalid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_late got %b exp 0", out_valid); end
        manual_rvalid = 1'b0;
        auto_mem = 1'b1;
        wait_states = 0;
        reset = 1'b1;
        tick();
        checks++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 32'h0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_restart got %b/%h/%b exp 1/0/0", mem.imem_req, mem.imem_addr, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || PC !== 32'h4 || Instruction !== mem_word(32'h0)) begin errors++; $display("[TB] FAIL rmid_first got %b/%h/%h exp 1/00000004/%h", out_valid, PC, Instruction, mem_word(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_branch_wait();
        test_branch_full();
        test_pc_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got no completion exp finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
